// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift register sequencer.
// Op encodings, FSM states and the default width.
package shift_reg_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] OP_SHL   = 2'd0;
  localparam logic [1:0] OP_SHR   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_RESP
  } state_t;

endpackage

// File: rtl/bidirectional_shift_register.sv
// Bidirectional shift register with serial inputs at both ends.
// Left shift has priority if both controls are high.
module bidirectional_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (shift_left) begin
      q <= {q[WIDTH-2:0], serial_in_left};
    end else if (shift_right) begin
      q <= {serial_in_right, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving a bidirectional shift register.
// Runs SHL/SHR/LOAD/CLEAR and returns the final register value.
module shift_reg_sequencer
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic             busy,
  input  logic [WIDTH-1:0] q,
  output logic             shift_left,
  output logic             shift_right,
  output logic             serial_in_left,
  output logic             serial_in_right
);

  state_t           state, state_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] num, num_n;
  logic             dir_l, dir_l_n;
  logic [WIDTH-1:0] dat, dat_n;
  logic             sl_n, sr_n, sil_n, sir_n;
  logic             rv_n;
  logic [WIDTH-1:0] rq_n;
  logic [CNT_W-1:0] cnt_eff;
  logic [WIDTH-1:0] rev;
  logic [CNT_W-1:0] sel;
  logic             bit_v;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);

  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = cmd_data[WIDTH-1-i];
    end
  end

  assign cnt_eff = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH)
                                               : cmd_count;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    num_n   = num;
    dir_l_n = dir_l;
    dat_n   = dat;
    rv_n    = rsp_valid;
    rq_n    = rsp_q;
    sl_n    = 1'b0;
    sr_n    = 1'b0;
    sil_n   = 1'b0;
    sir_n   = 1'b0;
    sel     = '0;
    bit_v   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_n = '0;
          unique case (cmd_op)
            OP_SHL: begin
              num_n = cnt_eff; dir_l_n = 1'b1; dat_n = cmd_data;
            end
            OP_SHR: begin
              num_n = cnt_eff; dir_l_n = 1'b0; dat_n = cmd_data;
            end
            OP_LOAD: begin
              num_n = CNT_W'(WIDTH); dir_l_n = 1'b1; dat_n = rev;
            end
            default: begin
              num_n = CNT_W'(WIDTH); dir_l_n = 1'b0; dat_n = '0;
            end
          endcase
          if (num_n == '0) begin
            state_n = S_CAPTURE;
          end else begin
            state_n = S_SHIFT;
            sl_n    = dir_l_n;
            sr_n    = !dir_l_n;
            bit_v   = dat_n[0];
          end
        end
      end
      S_SHIFT: begin
        if (idx + CNT_W'(1) == num) begin
          state_n = S_CAPTURE;
        end else begin
          idx_n = idx + CNT_W'(1);
          sel   = idx_n;
          sl_n  = dir_l;
          sr_n  = !dir_l;
          bit_v = |(dat & (WIDTH'(1) << sel));
        end
      end
      S_CAPTURE: begin
        rq_n    = q;
        rv_n    = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rv_n    = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    sil_n = sl_n & bit_v;
    sir_n = sr_n & bit_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= '0;
      num             <= '0;
      dir_l           <= 1'b0;
      dat             <= '0;
      rsp_valid       <= 1'b0;
      rsp_q           <= '0;
      shift_left      <= 1'b0;
      shift_right     <= 1'b0;
      serial_in_left  <= 1'b0;
      serial_in_right <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      num             <= num_n;
      dir_l           <= dir_l_n;
      dat             <= dat_n;
      rsp_valid       <= rv_n;
      rsp_q           <= rq_n;
      shift_left      <= sl_n;
      shift_right     <= sr_n;
      serial_in_left  <= sil_n;
      serial_in_right <= sir_n;
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench: sequencer driving the real 4-bit register.
// Each task checks one scenario against hand-computed values.
module tb_shift_reg_sequencer;
  import shift_reg_pkg::*;

  localparam int W = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_q;
  logic          busy;
  logic [W-1:0]  q;
  logic          shift_left;
  logic          shift_right;
  logic          serial_in_left;
  logic          serial_in_right;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
    .busy(busy), .q(q),
    .shift_left(shift_left), .shift_right(shift_right),
    .serial_in_left(serial_in_left), .serial_in_right(serial_in_right)
  );

  bidirectional_shift_register #(.WIDTH(W)) reg_i (
    .clk(clk), .rst(rst),
    .shift_left(shift_left), .shift_right(shift_right),
    .serial_in_left(serial_in_left), .serial_in_right(serial_in_right),
    .q(q)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, acks the response, and reports what it saw.
  task automatic run_cmd(
    input  logic [1:0]    op,
    input  logic [CW-1:0] cnt,
    input  logic [W-1:0]  data,
    output int            nl,
    output int            nr,
    output logic [7:0]    lbits,
    output logic [7:0]    rbits,
    output logic [15:0]   hist,
    output logic [W-1:0]  rq,
    output int            lat,
    output int            both
  );
    int cyc;
    int guard;
    logic prev;
    nl = 0; nr = 0; lat = -1; both = 0;
    lbits = 8'hFF; rbits = 8'hFF; hist = '0; rq = 'x;
    prev = 1'b0;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      step();
      guard++;
    end
    cmd_op = op; cmd_count = cnt; cmd_data = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      if (prev) hist = {hist[11:0], q};
      prev = shift_left | shift_right;
      if (shift_left && shift_right) both++;
      if (shift_left) begin
        nl++;
        lbits = {lbits[6:0], serial_in_left};
      end
      if (shift_right) begin
        nr++;
        rbits = {rbits[6:0], serial_in_right};
      end
      if (rsp_valid) begin
        lat = cyc;
        rq  = rsp_q;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({shift_left, shift_right, serial_in_left, serial_in_right,
         rsp_valid, busy, cmd_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
        {shift_left, shift_right, serial_in_left, serial_in_right,
         rsp_valid, busy, cmd_ready});
    end
    checks++;
    if (rsp_q !== 4'b0000 || q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_data rsp_q=%b q=%b want 0000", rsp_q, q);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b busy=%b rv=%b want 1 0 0",
        cmd_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_load();
    int nl, nr, lat, both;
    logic [7:0] lb, rb;
    logic [15:0] h;
    logic [W-1:0] rq;
    run_cmd(OP_LOAD, 3'd0, 4'b1011, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (nl !== 4 || nr !== 0 || both !== 0) begin
      errors++;
      $display("FAIL load_pulses nl=%0d nr=%0d both=%0d want 4 0 0", nl, nr, both);
    end
    checks++;
    if (lb[3:0] !== 4'b1011) begin
      errors++;
      $display("FAIL load_serial got %b want 1011", lb[3:0]);
    end
    checks++;
    if (rq !== 4'b1011 || lat !== 6) begin
      errors++;
      $display("FAIL load_rsp rsp_q=%b lat=%0d want 1011 6", rq, lat);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_after ready=%b rv=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_shl();
    int nl, nr, lat, both;
    logic [7:0] lb, rb;
    logic [15:0] h;
    logic [W-1:0] rq;
    run_cmd(OP_SHL, 3'd2, 4'b0001, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (nl !== 2 || nr !== 0) begin
      errors++;
      $display("FAIL shl_pulses nl=%0d nr=%0d want 2 0", nl, nr);
    end
    checks++;
    if (h[7:0] !== 8'b0111_1110) begin
      errors++;
      $display("FAIL shl_q_seq got %b want 01111110", h[7:0]);
    end
    checks++;
    if (rq !== 4'b1110 || lat !== 4) begin
      errors++;
      $display("FAIL shl_rsp rsp_q=%b lat=%0d want 1110 4", rq, lat);
    end
  endtask

  task automatic test_shr();
    int nl, nr, lat, both;
    logic [7:0] lb, rb;
    logic [15:0] h;
    logic [W-1:0] rq;
    run_cmd(OP_SHR, 3'd3, 4'b0101, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (nr !== 3 || nl !== 0 || rb[2:0] !== 3'b101) begin
      errors++;
      $display("FAIL shr_pulses nr=%0d nl=%0d bits=%b want 3 0 101",
        nr, nl, rb[2:0]);
    end
    checks++;
    if (h[11:0] !== 12'b1111_0111_1011) begin
      errors++;
      $display("FAIL shr_q_seq got %b want 111101111011", h[11:0]);
    end
    checks++;
    if (rq !== 4'b1011 || lat !== 5) begin
      errors++;
      $display("FAIL shr_rsp rsp_q=%b lat=%0d want 1011 5", rq, lat);
    end
  endtask

  task automatic test_clear();
    int nl, nr, lat, both;
    logic [7:0] lb, rb;
    logic [15:0] h;
    logic [W-1:0] rq;
    run_cmd(OP_CLEAR, 3'd1, 4'b1111, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (nr !== 4 || nl !== 0 || rb[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL clear_pulses nr=%0d nl=%0d bits=%b want 4 0 0000",
        nr, nl, rb[3:0]);
    end
    checks++;
    if (rq !== 4'b0000 || lat !== 6) begin
      errors++;
      $display("FAIL clear_rsp rsp_q=%b lat=%0d want 0000 6", rq, lat);
    end
  endtask

  task automatic test_count_bounds();
    int nl, nr, lat, both;
    logic [7:0] lb, rb;
    logic [15:0] h;
    logic [W-1:0] rq;
    run_cmd(OP_LOAD, 3'd0, 4'b0110, nl, nr, lb, rb, h, rq, lat, both);
    run_cmd(OP_SHL, 3'd0, 4'b1111, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (nl !== 0 || nr !== 0 || rq !== 4'b0110 || lat !== 2) begin
      errors++;
      $display("FAIL count_zero nl=%0d nr=%0d rsp_q=%b lat=%0d want 0 0 0110 2",
        nl, nr, rq, lat);
    end
    run_cmd(OP_SHL, 3'd7, 4'b1001, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (nl !== 4 || nr !== 0 || rq !== 4'b1001 || lat !== 6) begin
      errors++;
      $display("FAIL count_clamp nl=%0d nr=%0d rsp_q=%b lat=%0d want 4 0 1001 6",
        nl, nr, rq, lat);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    cmd_op = OP_LOAD; cmd_count = 3'd0; cmd_data = 4'b1001;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout rsp_valid=%b want 1", rsp_valid);
    end
    cmd_op = OP_SHL; cmd_count = 3'd3; cmd_data = 4'b1111;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_q !== 4'b1001 || cmd_ready !== 1'b0 ||
          shift_left !== 1'b0 || q !== 4'b1001) begin
        errors++;
        $display("FAIL bp_hold[%0d] rv=%b rsp_q=%b ready=%b sl=%b q=%b want 1 1001 0 0 1001",
          i, rsp_valid, rsp_q, cmd_ready, shift_left, q);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ready=%b rv=%b busy=%b want 1 0 0",
        cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    int nl, nr, lat, both, seen;
    logic [7:0] lb, rb;
    logic [15:0] h;
    logic [W-1:0] rq;
    cmd_op = OP_SHL; cmd_count = 3'd3; cmd_data = 4'b0111;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({shift_left, shift_right, serial_in_left, serial_in_right,
         rsp_valid, busy, cmd_ready} !== 7'b0 ||
        rsp_q !== 4'b0000 || q !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs ctrl=%b rsp_q=%b q=%b want 0",
        {shift_left, shift_right, serial_in_left, serial_in_right,
         rsp_valid, busy, cmd_ready}, rsp_q, q);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid || shift_left) seen++;
    end
    checks++;
    if (seen !== 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_no_rsp seen=%0d ready=%b want 0 1", seen, cmd_ready);
    end
    run_cmd(OP_LOAD, 3'd0, 4'b0101, nl, nr, lb, rb, h, rq, lat, both);
    checks++;
    if (rq !== 4'b0101 || lat !== 6 || nl !== 4) begin
      errors++;
      $display("FAIL midrst_next rsp_q=%b lat=%0d nl=%0d want 0101 6 4",
        rq, lat, nl);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_count = '0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_load();
    test_shl();
    test_shr();
    test_clear();
    test_count_bounds();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

- Command sequencer for the 4-bit `bidirectional_shift_register`.
- Accepts one command at a time over a valid/ready handshake: shift left, shift right, parallel load or clear.
- Drives the register's `shift_left`/`shift_right`/`serial_in_*` pins for the required number of cycles, then returns the final register contents over a valid/ready response channel.
- Sits beside the register in the top level; both share `clk` and `rst`.

## Interface
Parameters:
- `WIDTH`, default 4: register width; must equal the attached register's width.
- Derived localparam `CNT_W = $clog2(WIDTH)+1`: count field width.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous reset, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_op` input 2: 0=SHL, 1=SHR, 2=LOAD, 3=CLEAR.
- `cmd_count` input CNT_W: number of shifts; used by SHL/SHR only.
- `cmd_data` input WIDTH: serial bits. For SHL/SHR, bit i is fed on shift i. For LOAD, it is the parallel value.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed.
- `rsp_q` output WIDTH: register value captured at command end.
- `busy` output 1: a command is in progress (not IDLE).
- `q` input WIDTH: register output readback.
- `shift_left` output 1: register control.
- `shift_right` output 1: register control.
- `serial_in_left` output 1: register serial input.
- `serial_in_right` output 1: register serial input.

## Operation
Register model:
- `shift_left`: q ← {q[WIDTH-2:0], serial_in_left}.
- `shift_right`: q ← {serial_in_right, q[WIDTH-1:1]}.
- The sequencer never asserts `shift_left` and `shift_right` in the same cycle.

FSM states: IDLE, SHIFT, CAPTURE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`: latch op, effective count N and data; go to SHIFT, or to CAPTURE if N=0.
- SHIFT:
  - Assert exactly one direction line.
  - The serial line carries the current data bit; the other serial line is 0.
  - Increment the shift index; after the N-th cycle, go to CAPTURE.
- CAPTURE:
  - All control outputs are 0.
  - At the end of the cycle: `rsp_q` ← `q`, `rsp_valid` ← 1; go to RESP.
- RESP:
  - Hold `rsp_valid` and `rsp_q` stable until `rsp_ready`.
  - On handshake, go to IDLE.

Per-op behaviour:
- SHL: N = min(`cmd_count`, WIDTH). Drive `shift_left`; shift i feeds `cmd_data[i]`.
- SHR: N as SHL. Drive `shift_right`; shift i feeds `cmd_data[i]` on `serial_in_right`.
- LOAD: N = WIDTH. Drive `shift_left`, feeding `cmd_data` MSB first, so the final q = `cmd_data`. `cmd_count` is ignored.
- CLEAR: N = WIDTH. Drive `shift_right` with `serial_in_right`=0, so the final q = 0. `cmd_count` and `cmd_data` are ignored.

Boundary conditions:
- `cmd_count` > WIDTH is clamped to WIDTH. `cmd_count`=0 is legal and produces no shifts.
- `cmd_valid` outside IDLE is ignored: no queuing and no side effects.
- `rsp_ready` while `rsp_valid`=0 is ignored.
- `rst` in any state:
  - Next cycle: state IDLE; `shift_left`, `shift_right`, `serial_in_left`, `serial_in_right`, `rsp_valid`, `busy` = 0; `rsp_q` = 0.
  - The in-flight command is discarded with no response.
  - `cmd_ready` is 0 while `rst` is high and 1 from the first cycle after release.

## Timing
- Cycle 0 is the acceptance edge.
- Control outputs are registered:
  - Shift lines are high in cycles 1..N.
  - The register updates at edges 2..N+1.
- CAPTURE is cycle N+1; `rsp_valid` rises in cycle N+2.
- With N=0, `rsp_valid` rises in cycle 2.
- `cmd_ready` returns in the cycle after the response handshake.
- Minimum command-to-command spacing is N+3 cycles.
- `busy` = (state ≠ IDLE).
- `rsp_q` changes only at the CAPTURE edge or on reset.

## Structure
Shared package `shift_reg_pkg`:
- op encoding constants `OP_SHL`, `OP_SHR`, `OP_LOAD`, `OP_CLEAR`;
- FSM state typedef;
- default WIDTH.

Module layout:
- Single module; no sub-module needed. Shift index counter and FSM are inline.
- The top level instantiates `shift_reg_sequencer` and `bidirectional_shift_register` as siblings.

## Test plan
WIDTH=4, sequencer connected to the real register.
1. Reset, then LOAD `cmd_data`=1011 → `shift_left` high for 4 cycles with `serial_in_left` = 1,0,1,1; `rsp_q`=1011; `rsp_valid` first high in cycle 6 after acceptance.
2. From q=1011, SHL count=2 data=0001 → q goes 0111 then 1110; `rsp_q`=1110; `shift_right` stays 0 throughout.
3. From q=1110, SHR count=3 data=0101 → q goes 1111, 0111, 1011; `rsp_q`=1011.
4. CLEAR → `shift_right` high for 4 cycles with `serial_in_right`=0; `rsp_q`=0000.
5. SHL count=0 → no shift pulses and `rsp_q` = current q in cycle 2. SHL count=7 → exactly 4 `shift_left` pulses.
6. Response backpressure and mid-command reset:
   - Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_q` stable, `cmd_ready`=0, and a concurrent `cmd_valid` is ignored.
   - Assert `rst` during SHIFT → next cycle all outputs are 0, q=0000, no response appears; the next command runs normally.
